// File: rtl/vector_wb_sequencer.sv
// Vector writeback sequencer: captures a LANES-wide result + mask and writes it to the lane-banked VRF one lane per cycle.
// Latency: lane k presented k+1 cycles after capture; done pulses one cycle after the final lane slot.
// Backpressure: stall/busy held high for the whole write walk; in_valid is ignored (not captured) while stalled.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_vreg/in_data/in_mask   vector result from execute (lane k = in_data[k*DATA_W +: DATA_W])
//   flush               abort the current walk; no done pulse
//   stall, busy         hold upstream (identical; busy is for debug/perf counters)
//   done                one-cycle pulse after the final lane slot
//   rf_we/rf_vreg/rf_lane/rf_wdata     VRF lane write port, all zero outside WRITE
//
// Build option: define VWB_MASK_SKIP_EN to walk only the lanes whose mask bit is set.
module vector_wb_sequencer #(
  parameter int  LANES  = 4,
  parameter int  DATA_W = 8,
  parameter int  REG_AW = 3,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [REG_AW-1:0]       in_vreg,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic [LANES-1:0]        in_mask,
  input  logic                    flush,
  output logic                    stall,
  output logic                    busy,
  output logic                    done,
  output logic                    rf_we,
  output logic [REG_AW-1:0]       rf_vreg,
  output logic [LANE_W-1:0]       rf_lane,
  output logic [DATA_W-1:0]       rf_wdata
);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t                  state_q;
  logic [LANE_W-1:0]       lane_q;
  logic [REG_AW-1:0]       vreg_q;
  logic [LANES*DATA_W-1:0] data_q;
  logic [LANES-1:0]        mask_q;
  logic                    done_q;

`ifdef VWB_MASK_SKIP_EN
  // Lowest set lane of the incoming mask (start point of the walk) and the
  // lowest set lane strictly above the current one (next slot, if any).
  // Descending scans so the last hit is the lowest qualifying lane.
  logic [LANE_W-1:0] first_lane;
  logic [LANE_W-1:0] next_lane;
  logic              next_found;

  always_comb begin
    first_lane = '0;
    next_lane  = '0;
    next_found = 1'b0;
    for (int k = LANES - 1; k >= 0; k--) begin
      if (in_mask[k]) begin
        first_lane = LANE_W'(k);
      end
      if (mask_q[k] && (LANE_W'(k) > lane_q)) begin
        next_lane  = LANE_W'(k);
        next_found = 1'b1;
      end
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lane_q  <= '0;
      vreg_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      done_q  <= 1'b0;
    end else if (flush) begin
      // The lane presented this cycle is still written (rf_we is not gated
      // by flush); nothing after it is, and no done pulse is produced.
      state_q <= IDLE;
      lane_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            vreg_q <= in_vreg;
            data_q <= in_data;
            mask_q <= in_mask;
`ifdef VWB_MASK_SKIP_EN
            if (in_mask == '0) begin
              // Nothing to write: finish immediately without stalling.
              done_q <= 1'b1;
            end else begin
              lane_q  <= first_lane;
              state_q <= WRITE;
            end
`else
            lane_q  <= '0;
            state_q <= WRITE;
`endif
          end
        end
        WRITE: begin
`ifdef VWB_MASK_SKIP_EN
          if (next_found) begin
            lane_q <= next_lane;
          end else begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
`else
          if (lane_q == LAST_LANE) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            lane_q <= lane_q + 1'b1;
          end
`endif
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign stall = (state_q == WRITE);
  assign busy  = stall;
  assign done  = done_q;

  // VRF port is driven straight from the captured registers; it reads zero
  // whenever no lane slot is active so idle cycles never look like writes.
  always_comb begin
    rf_we    = 1'b0;
    rf_vreg  = '0;
    rf_lane  = '0;
    rf_wdata = '0;
    if (state_q == WRITE) begin
      rf_we    = mask_q[lane_q];
      rf_vreg  = vreg_q;
      rf_lane  = lane_q;
      rf_wdata = data_q[lane_q*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_vector_wb_sequencer.sv
// Scoreboard bench for vector_wb_sequencer: directed test-plan scenarios followed by random traffic.
// The driver predicts every lane write, stall cycle and done pulse from the sequencing rules;
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vector_wb_sequencer;

  localparam int LANES  = 4;
  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int LANE_W = 2;
  localparam int MAXC   = 8192;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [REG_AW-1:0]       in_vreg;
  logic [LANES*DATA_W-1:0] in_data;
  logic [LANES-1:0]        in_mask;
  logic                    flush;
  logic                    stall;
  logic                    busy;
  logic                    done;
  logic                    rf_we;
  logic [REG_AW-1:0]       rf_vreg;
  logic [LANE_W-1:0]       rf_lane;
  logic [DATA_W-1:0]       rf_wdata;

  vector_wb_sequencer #(.LANES(LANES), .DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_vreg(in_vreg), .in_data(in_data),
    .in_mask(in_mask), .flush(flush), .stall(stall), .busy(busy), .done(done),
    .rf_we(rf_we), .rf_vreg(rf_vreg), .rf_lane(rf_lane), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Cycle n is the period following the n-th rising edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int                cyc;
    logic [REG_AW-1:0] vreg;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];
  bit  exp_stall [MAXC];
  int  idle_from = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Flush or reset sampled at the end of cycle c: anything already presented
  // stands, everything predicted after c is cancelled.
  task automatic purge(input int c);
    wr_t keep[$];
    int  dkeep[$];
    foreach (wq[i]) if (wq[i].cyc <= c) keep.push_back(wq[i]);
    wq = keep;
    foreach (dq[i]) if (dq[i] <= c) dkeep.push_back(dq[i]);
    dq = dkeep;
    for (int k = c + 1; k < MAXC && k <= c + LANES + 1; k++) exp_stall[k] = 1'b0;
    idle_from = c + 1;
  endtask

  // Capture at the end of cycle c: list the slots the walk will produce.
  task automatic model_capture(input int c, input logic [REG_AW-1:0] vr,
                               input logic [LANES*DATA_W-1:0] d, input logic [LANES-1:0] m);
    int  n;
    wr_t e;
    n = 0;
    for (int k = 0; k < LANES; k++) begin
      e.vreg = vr;
      e.lane = LANE_W'(k);
      e.data = d[k*DATA_W +: DATA_W];
`ifdef VWB_MASK_SKIP_EN
      if (m[k]) begin
        e.cyc = c + 1 + n;
        wq.push_back(e);
        n++;
      end
`else
      e.cyc = c + 1 + k;
      if (m[k]) wq.push_back(e);
      n++;
`endif
    end
    for (int k = 1; k <= n; k++) exp_stall[c + k] = 1'b1;
    dq.push_back(c + n + 1);
    idle_from = c + n + 1;
  endtask

  // Drive one cycle's inputs (called #1 after a rising edge) and predict.
  task automatic drive(input bit v, input bit f, input bit r, input logic [REG_AW-1:0] vr,
                       input logic [LANES*DATA_W-1:0] d, input logic [LANES-1:0] m);
    int c;
    c = cyc;
    in_valid = v; flush = f; rst = r; in_vreg = vr; in_data = d; in_mask = m;
    if (r || f) purge(c);
    else if (v && c >= idle_from) model_capture(c, vr, d, m);
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Monitor: compares mid-cycle, away from the active edge.
  always @(negedge clk) begin
    int  c;
    wr_t e;
    int  dc;
    if (mon_en) begin
      c = cyc;
      while (wq.size() > 0 && wq[0].cyc < c) begin
        e = wq.pop_front();
        checks++; errors++;
        $display("FAIL missing_write: lane %0d data 0x%0h expected in cycle %0d, never seen", e.lane, e.data, e.cyc);
      end
      while (dq.size() > 0 && dq[0] < c) begin
        dc = dq.pop_front();
        checks++; errors++;
        $display("FAIL missing_done: done expected in cycle %0d, never seen", dc);
      end
      if (rf_we === 1'b1) begin
        if (wq.size() == 0 || wq[0].cyc != c) begin
          checks++; errors++;
          $display("FAIL unexpected_write @cycle %0d: got lane %0d data 0x%0h, expected no write", c, rf_lane, rf_wdata);
        end else begin
          e = wq.pop_front();
          check("rf_vreg", 64'(rf_vreg), 64'(e.vreg));
          check("rf_lane", 64'(rf_lane), 64'(e.lane));
          check("rf_wdata", 64'(rf_wdata), 64'(e.data));
        end
      end
      if (done === 1'b1) begin
        if (dq.size() == 0 || dq[0] != c) begin
          checks++; errors++;
          $display("FAIL unexpected_done @cycle %0d: got done=1, expected 0", c);
        end else begin
          dc = dq.pop_front();
          check("done_cycle", 64'(c), 64'(dc));
        end
      end
      check("stall", 64'(stall), 64'(exp_stall[c]));
      check("busy", 64'(busy), 64'(exp_stall[c]));
      if (!exp_stall[c])
        check("idle_rf_outputs", 64'({rf_we, rf_vreg, rf_lane, rf_wdata}), 64'd0);
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_vreg = '0; in_data = '0; in_mask = '0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_rf", 64'({rf_we, rf_vreg, rf_lane, rf_wdata}), 64'd0);
    idle_from = cyc;
    mon_en = 1'b1;
    idle(2);

    // Full mask
    drive(1'b1, 1'b0, 1'b0, 3'd5, 32'h44332211, 4'b1111);
    idle(6);
    // Partial mask
    drive(1'b1, 1'b0, 1'b0, 3'd3, 32'hDDCCBBAA, 4'b0101);
    idle(6);
    // Back-to-back: second vector held from T+1, taken in the done cycle
    drive(1'b1, 1'b0, 1'b0, 3'd1, 32'h0D0C0B0A, 4'b1111);
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 3'd2, 32'h9C8B7A69, 4'b1111);
    idle(6);
    // Flush at T+2
    drive(1'b1, 1'b0, 1'b0, 3'd6, 32'h55667788, 4'b1111);
    idle(1);
    drive(1'b0, 1'b1, 1'b0, '0, '0, '0);
    idle(6);
    // Flush in IDLE alongside in_valid: no capture
    drive(1'b1, 1'b1, 1'b0, 3'd7, 32'hFFEEDDCC, 4'b1111);
    idle(6);
    // Reset at T+3, then a fresh vector
    drive(1'b1, 1'b0, 1'b0, 3'd4, 32'h12345678, 4'b1111);
    idle(2);
    drive(1'b0, 1'b0, 1'b1, '0, '0, '0);
    idle(1);
    drive(1'b1, 1'b0, 1'b0, 3'd2, 32'hA1B2C3D4, 4'b1011);
    idle(6);
    // Zero mask
    drive(1'b1, 1'b0, 1'b0, 3'd0, 32'hCAFEF00D, 4'b0000);
    idle(6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      drive($urandom_range(0, 99) < 65, r < 3, r >= 97, REG_AW'($urandom),
            {$urandom}, LANES'($urandom_range(0, 15)));
    end
    idle(10);

    checks++;
    if (wq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d writes and %0d done pulses still pending, expected 0 and 0", wq.size(), dq.size());
    end
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
